inc_dec_ham_unit: RTL and testbench
===================================

# inc_dec_ham_unit

Registered single-operand 32-bit arithmetic unit providing increment (with carry-out), decrement (with borrow-out) and Hamming weight (population count). It sits in the ALU's unary-operation path. The ALU issues one operand and an opcode per cycle and receives the result one cycle later.

## Interface
Parameters:
- none. The width is fixed at 32 bits.

Ports:
- `clk` — input, 1 bit. The single clock; all state changes on its rising edge.
- `rst_n` — input, 1 bit. Reset, synchronous and active-low.
- `in_valid` — input, 1 bit. Operand and opcode are presented this cycle.
- `op` — input, 2 bits. Operation select:
  - 2'b00 INC
  - 2'b01 DEC
  - 2'b10 HAM
  - 2'b11 reserved
- `a` — input, 32 bits. Operand.
- `result` — output, 32 bits. Registered operation result.
- `flag` — output, 1 bit. Registered carry-out (INC) or borrow-out (DEC); 0 for all other operations.
- `out_valid` — output, 1 bit. `result` and `flag` are valid this cycle.

## Operation
- INC: `result = a + 1` modulo 2^32.
  - `flag` = carry out of bit 31.
  - `flag` = 1 only when `a` = 32'hFFFFFFFF.
- DEC: `result = a - 1` modulo 2^32.
  - `flag` = borrow out of bit 31.
  - `flag` = 1 only when `a` = 32'h00000000.
- `flag` reports unsigned carry/borrow only; signed overflow is not flagged.
  - 32'h7FFFFFFF INC gives 32'h80000000 with `flag` 0.
  - 32'h80000000 DEC gives 32'h7FFFFFFF with `flag` 0.
- HAM: `result` = number of 1 bits in `a`, range 0..32, zero-extended to 32 bits. `flag` = 0.
- Reserved op (2'b11): `result` = 0, `flag` = 0, `out_valid` still asserted.
- No internal state beyond the output registers.

## Timing
- Latency is one cycle: inputs sampled on rising edge N appear on the outputs after that edge, and `out_valid` is high for cycle N+1.
- `out_valid` is `in_valid` registered. The unit accepts one operation per cycle with no backpressure.
- When `in_valid` = 0 at an edge:
  - `out_valid` goes to 0.
  - `result` and `flag` hold their previous values.
- Reset values, applied at a rising edge with `rst_n` = 0:
  - `result` = 0
  - `flag` = 0
  - `out_valid` = 0
- Reset takes priority over `in_valid`. An operation presented in the same cycle as reset is discarded.
- Back-to-back operations of different types produce consecutive valid outputs with no bubble.

## Configuration
- Macro `INC_DEC_HAM_UNIT_HAM_EN`.
- Defined: the HAM operation is implemented as specified above.
- Undefined:
  - The popcount logic is omitted.
  - op 2'b10 behaves as reserved: `result` = 0, `flag` = 0, `out_valid` asserted.
  - INC and DEC are unaffected.

## Structure
- Shared package `inc_dec_ham_pkg` holds:
  - Opcode localparams `OP_INC`, `OP_DEC`, `OP_HAM`, `OP_RSVD`.
  - The data width constant (32).
  - The popcount result width constant (6).
- One sub-module, `ham_popcount`: a combinational 32-bit adder-tree population count with a 6-bit output. It is instantiated only under `INC_DEC_HAM_UNIT_HAM_EN`.
- INC/DEC use a single 33-bit add/subtract in the top module. The top module also holds the output mux and the registers.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles while `in_valid` = 1, op INC, a = 5 → `result` = 0, `flag` = 0, `out_valid` = 0 throughout.
- INC:
  - a = 32'h00000005 → 32'h00000006, `flag` 0.
  - a = 32'h7FFFFFFF → 32'h80000000, `flag` 0.
  - a = 32'hFFFFFFFF → 32'h00000000, `flag` 1.
- DEC:
  - a = 32'h0000000F → 32'h0000000E, `flag` 0.
  - a = 32'h80000000 → 32'h7FFFFFFF, `flag` 0.
  - a = 32'h00000000 → 32'hFFFFFFFF, `flag` 1.
- HAM:

  | a | result |
  |---|---|
  | 32'h00000000 | 0 |
  | 32'h00000001 | 1 |
  | 32'h0000000F | 4 |
  | 32'h000000FF | 8 |
  | 32'hAAAAAAAA | 16 |
  | 32'hFFFFFFEC | 29 |
  | 32'hFFFFFFFF | 32 |

  `flag` is 0 in every case.
- Pipelining: issue INC a = 32'hFFFFFFFF, then DEC 0, then HAM 32'h80 on consecutive cycles, then drop `in_valid`.
  - Outputs on consecutive cycles: (0, 1), (FFFFFFFF, 1), (1, 0).
  - Then `out_valid` drops to 0 and `result` holds 1.
- Reserved op 2'b11 with a = 32'h12345678 → `result` 0, `flag` 0, `out_valid` 1. Rerun the HAM cases with the macro undefined → `result` 0 for each.

Source files
------------

// File: rtl/inc_dec_ham_pkg.sv
// Shared constants for the unary inc/dec/popcount unit.
package inc_dec_ham_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_HAM  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

endpackage

// File: rtl/ham_popcount.sv
// Combinational 32-bit population count built as a balanced adder tree.
module ham_popcount
  import inc_dec_ham_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  output logic [CNT_W-1:0]  cnt
);

  logic [15:0][1:0] s1;
  logic [7:0][2:0]  s2;
  logic [3:0][3:0]  s3;
  logic [1:0][4:0]  s4;

  // Each level adds adjacent pairs, widening by one bit to hold the carry.
  for (genvar i = 0; i < 16; i++) begin : g_l1
    assign s1[i] = {1'b0, a[2*i]} + {1'b0, a[2*i+1]};
  end
  for (genvar i = 0; i < 8; i++) begin : g_l2
    assign s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
  end
  for (genvar i = 0; i < 4; i++) begin : g_l3
    assign s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
  end
  for (genvar i = 0; i < 2; i++) begin : g_l4
    assign s4[i] = {1'b0, s3[2*i]} + {1'b0, s3[2*i+1]};
  end

  assign cnt = {1'b0, s4[0]} + {1'b0, s4[1]};

endmodule

// File: rtl/inc_dec_ham_unit.sv
// Registered 32-bit increment / decrement / popcount unit, one-cycle latency.
// Define INC_DEC_HAM_UNIT_HAM_EN to build the popcount; otherwise HAM acts as reserved.
module inc_dec_ham_unit
  import inc_dec_ham_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] result,
  output logic              flag,
  output logic              out_valid
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result_nxt;
  logic              flag_nxt;
  logic [DATA_W-1:0] ham_res;

`ifdef INC_DEC_HAM_UNIT_HAM_EN
  logic [CNT_W-1:0] ham_cnt;

  ham_popcount u_pop (
    .a   (a),
    .cnt (ham_cnt)
  );

  assign ham_res = {{(DATA_W-CNT_W){1'b0}}, ham_cnt};
`else
  assign ham_res = '0;
`endif

  // One shared 33-bit adder; bit 32 is the carry (INC) or borrow (DEC).
  always_comb begin
    sum = '0;
    if (op == OP_DEC) sum = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
    else              sum = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
  end

  always_comb begin
    result_nxt = '0;
    flag_nxt   = 1'b0;
    case (op)
      OP_INC, OP_DEC: begin
        result_nxt = sum[DATA_W-1:0];
        flag_nxt   = sum[DATA_W];
      end
      OP_HAM:  result_nxt = ham_res;
      default: result_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      flag      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= result_nxt;
        flag   <= flag_nxt;
      end
    end
  end

endmodule

// File: tb/tb_inc_dec_ham_unit.sv
// Self-checking bench: directed cases plus random traffic against an arithmetic model.
module tb_inc_dec_ham_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] result;
  logic        flag;
  logic        out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_r = '0;
  logic        exp_f = 1'b0;
  logic        exp_v = 1'b0;

  inc_dec_ham_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .result    (result),
    .flag      (flag),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour straight from the operation rules.
  task automatic model(input logic [1:0] o, input logic [31:0] x,
                       output logic [31:0] r, output logic f);
    longint t;
    int     n;
    r = '0;
    f = 1'b0;
    case (o)
      2'd0: begin
        t = longint'(x) + 1;
        r = t[31:0];
        f = t[32];
      end
      2'd1: begin
        r = x - 32'd1;
        f = (x == 32'd0);
      end
      2'd2: begin
`ifdef INC_DEC_HAM_UNIT_HAM_EN
        n = 0;
        for (int i = 0; i < 32; i++) if (x[i]) n++;
        r = n;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".result"}, result, exp_r);
    chk({tag, ".flag"}, {31'd0, flag}, {31'd0, exp_f});
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, exp_v});
  endtask

  task automatic step(input string tag, input logic iv, input logic [1:0] o, input logic [31:0] x);
    logic [31:0] r;
    logic        f;
    in_valid = iv;
    op       = o;
    a        = x;
    @(posedge clk);
    exp_v = iv;
    if (iv) begin
      model(o, x, r, f);
      exp_r = r;
      exp_f = f;
    end
    #1;
    check_out(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    op       = 2'd0;
    a        = 32'd5;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      exp_r = '0;
      exp_f = 1'b0;
      exp_v = 1'b0;
      #1;
      check_out(tag);
    end
    rst_n = 1'b1;
  endtask

  logic [31:0] ham_vec [7] = '{32'h0, 32'h1, 32'hF, 32'hFF, 32'hAAAAAAAA, 32'hFFFFFFEC, 32'hFFFFFFFF};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = 2'd0;
    a        = '0;
    #2;
    do_reset("reset", 2);

    step("inc5",    1'b1, 2'd0, 32'h00000005);
    step("inc7f",   1'b1, 2'd0, 32'h7FFFFFFF);
    step("incff",   1'b1, 2'd0, 32'hFFFFFFFF);
    step("decf",    1'b1, 2'd1, 32'h0000000F);
    step("dec80",   1'b1, 2'd1, 32'h80000000);
    step("dec0",    1'b1, 2'd1, 32'h00000000);
    for (int i = 0; i < 7; i++) step($sformatf("ham%0d", i), 1'b1, 2'd2, ham_vec[i]);
    step("rsvd",    1'b1, 2'd3, 32'h12345678);

    // Back-to-back mixed ops, then a bubble that must hold the last result.
    step("pipe0",   1'b1, 2'd0, 32'hFFFFFFFF);
    step("pipe1",   1'b1, 2'd1, 32'h00000000);
    step("pipe2",   1'b1, 2'd2, 32'h00000080);
    step("idle0",   1'b0, 2'd0, 32'hDEADBEEF);
    step("idle1",   1'b0, 2'd1, 32'h00000000);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] x;
      case ($urandom_range(0, 3))
        0:       x = 32'hFFFFFFFF;
        1:       x = 32'h0;
        default: x = $urandom;
      endcase
      step("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), x);
    end

    do_reset("reset2", 1);
    step("post_rst", 1'b1, 2'd1, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
